// File: rtl/readout_collector.sv
// Readout collector: terminal consumer of the readout router chain.
// Buffers spin/psum words into a host valid/ready stream, holds flip requests
// toward the spin array, acknowledges them to the router, and keeps debug
// counters and sticky error flags.
// Optional frame counting is enabled by defining READOUT_COLLECTOR_FRAME_EN.
module readout_collector #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned AW          = 4,
    parameter int unsigned FRAME_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rd_word,
    output logic        flip_ack,
    output logic        flip_valid,
    output logic [28:0] flip_payload,
    input  logic        flip_ready,
    output logic        m_valid,
    output logic [31:0] m_data,
    input  logic        m_ready,
    input  logic        clr,
    output logic [15:0] spin_cnt,
    output logic [15:0] psum_cnt,
    output logic        ovf,
    output logic        err,
    output logic        frame_done
);

    // Reject parameter combinations the pointer arithmetic cannot support.
    if (DEPTH != (32'd1 << AW) || DEPTH < 2 || FRAME_WORDS < 2) begin : g_param_check
        $error("readout_collector: DEPTH must equal 2**AW (>=2), FRAME_WORDS >= 2");
    end

    typedef enum logic {HoldEmpty, HoldFull} flip_state_e;

    logic [2:0]  tag;
    logic        is_spin, is_psum, is_flip, is_rsvd;
    flip_state_e state_q, state_d;

    assign tag = rd_word[31:29];

    // Tag decode; tags 0 and 5 fall through as ignored.
    always_comb begin
        is_spin = 1'b0;
        is_psum = 1'b0;
        is_flip = 1'b0;
        is_rsvd = 1'b0;
        case (tag)
            3'd1:                is_spin = 1'b1;
            3'd2:                is_psum = 1'b1;
            3'd6:                is_flip = 1'b1;
            3'd3, 3'd4, 3'd7:    is_rsvd = 1'b1;
            default:             ;
        endcase
    end

    // Flip FSM next state and outputs; ack depends on rd_word and state only.
    always_comb begin
        state_d    = state_q;
        flip_ack   = 1'b0;
        flip_valid = 1'b0;
        case (state_q)
            HoldEmpty: begin
                if (is_flip && !rst) begin
                    flip_ack = 1'b1;
                    state_d  = HoldFull;
                end
            end
            HoldFull: begin
                flip_valid = 1'b1;
                if (flip_ready) state_d = HoldEmpty;
            end
            default: state_d = HoldEmpty;
        endcase
    end

    // Flip FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= HoldEmpty;
        else     state_q <= state_d;
    end

    // Capture the flip payload on the acknowledging edge.
    always_ff @(posedge clk) begin
        if (rst)           flip_payload <= '0;
        else if (flip_ack) flip_payload <= rd_word[28:0];
    end

    // ---------------- Readout FIFO ----------------
    logic [31:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, push_req, push_ok;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign m_valid  = !empty;
    assign m_data   = mem[rd_ptr[AW-1:0]];
    assign pop      = m_valid && m_ready;
    assign push_req = is_spin || is_psum;
    // A push at full is only accepted when a pop frees the slot in the same cycle.
    assign push_ok  = push_req && (!full || pop);

    // Storage write; contents are not reset, the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= rd_word;
    end

    // FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Saturating tag counters; clr takes priority over an increment.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            spin_cnt <= '0;
            psum_cnt <= '0;
        end else begin
            if (push_ok && is_spin && spin_cnt != 16'hFFFF) spin_cnt <= spin_cnt + 16'd1;
            if (push_ok && is_psum && psum_cnt != 16'hFFFF) psum_cnt <= psum_cnt + 16'd1;
        end
    end

    // Sticky flags; a new event in the clr cycle still leaves the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
            err <= 1'b0;
        end else begin
            ovf <= (ovf && !clr) || (push_req && !push_ok);
            err <= (err && !clr) || is_rsvd;
        end
    end

`ifdef READOUT_COLLECTOR_FRAME_EN
    localparam int unsigned FCW = (FRAME_WORDS > 2) ? $clog2(FRAME_WORDS) : 1;

    logic [FCW-1:0] frame_cnt;
    logic           frame_last;

    assign frame_last = (frame_cnt == FCW'(FRAME_WORDS - 1));

    // Frame counter over accepted spin pushes; pulse and wrap on the last word.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            frame_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (push_ok && is_spin) begin
                if (frame_last) begin
                    frame_cnt  <= '0;
                    frame_done <= 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end
`else
    assign frame_done = 1'b0;
`endif

endmodule
